// File: rtl/block_match_sad_engine.sv
// Block-match SAD engine: reads one block and its search band, accumulates SAD for
// every horizontal candidate offset in parallel, then scans for the lowest-SAD offset.
module block_match_sad_engine #(
  parameter int rd_port_w    = 8,
  parameter int third_w      = 240,
  parameter int center_w     = 304,
  parameter int block_width  = 16,
  parameter int block_height = 16,
  parameter int search_blk_w = 64,
  parameter int search_blk_h = 32,
  parameter int rd_lat       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bm_start,
  input  logic [15:0]            blk_addr,
  input  logic [15:0]            srch_addr,
  input  logic [15:0]            blk_index,
  output logic                   bm_done,
  output logic [15:0]            blk_rd_addr,
  input  logic [8*rd_port_w-1:0] blk_rd_data,
  output logic [15:0]            srch_rd_addr,
  input  logic [8*rd_port_w-1:0] srch_rd_data,
  output logic                   result_valid,
  output logic [15:0]            result_index,
  output logic [7:0]             result_disp,
  output logic [15:0]            result_sad
);

  localparam int bw          = block_width / rd_port_w;
  localparam int sw          = search_blk_w / rd_port_w;
  localparam int nc          = search_blk_w - block_width + 1;
  localparam int vofs        = (search_blk_h - block_height) / 2;
  localparam int blk_stride  = third_w / rd_port_w;
  localparam int srch_stride = center_w / rd_port_w;
  localparam int word_bits   = 8 * rd_port_w;
  localparam int wi_w        = (sw > 1) ? $clog2(sw) : 1;
  localparam int rw_w        = (block_height > 1) ? $clog2(block_height) : 1;
  localparam int sc_w        = (nc > 1) ? $clog2(nc) : 1;
  localparam int dr_w        = (rd_lat > 1) ? $clog2(rd_lat) : 1;

  localparam logic [wi_w-1:0] last_word = wi_w'(sw - 1);
  localparam logic [rw_w-1:0] last_row  = rw_w'(block_height - 1);
  localparam logic [sc_w-1:0] last_cand = sc_w'(nc - 1);
  localparam logic [dr_w-1:0] last_drn  = dr_w'(rd_lat - 1);
  localparam logic [15:0]     blk_step  = 16'(blk_stride);
  localparam logic [15:0]     srch_step = 16'(srch_stride);
  localparam logic [15:0]     srch_vofs = 16'(vofs * srch_stride);

  // idle: ready | read: issue reads | drain: wait for last row | scan: pick best | done: result pulse
  typedef enum logic [2:0] {
    st_idle,
    st_read,
    st_drain,
    st_scan,
    st_done
  } state_t;

  state_t state, state_next;

  logic                      start;
  logic                      read_last;
  logic                      row_last;
  logic [15:0]               idx_lat;
  logic [15:0]               blk_base;
  logic [15:0]               srch_base;
  logic [wi_w-1:0]           word_cnt;
  logic [rw_w-1:0]           row_cnt;
  logic [dr_w-1:0]           drain_cnt;
  logic [sc_w-1:0]           scan_idx;
  logic [15:0]               best_sad;
  logic [sc_w-1:0]           best_disp;
  logic                      take_cand;
  logic [15:0]               cand_sad;
  logic [15:0]               scan_best_sad;
  logic [sc_w-1:0]           scan_best_disp;
  logic [rd_lat-1:0]         pipe_v;
  logic [wi_w-1:0]           pipe_w [rd_lat];
  logic [block_width*8-1:0]  blk_row;
  logic [search_blk_w*8-1:0] srch_row;
  logic [search_blk_w*8-1:0] srch_full;
  logic [15:0]               sad_row [nc];
  logic [15:0]               acc [nc];

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign start     = bm_start && bm_done;
  assign read_last = (state == st_read) && (row_cnt == last_row) && (word_cnt == last_word);
  assign row_last  = pipe_v[rd_lat-1] && (pipe_w[rd_lat-1] == last_word);

  always_ff @(posedge clk) begin
    if (reset) state <= st_idle;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      st_idle:  if (bm_start) state_next = st_read;
      st_read:  if (read_last) state_next = st_drain;
      st_drain: if (drain_cnt == last_drn) state_next = st_scan;
      st_scan:  if (scan_idx == last_cand) state_next = st_done;
      st_done:  state_next = bm_start ? st_read : st_idle;
      default:  state_next = st_idle;
    endcase
  end

  always_comb begin
    bm_done      = (state == st_idle) || (state == st_done);
    result_valid = (state == st_done);
  end

  // Row/word counters and running row-base addresses; 16-bit wrap is intentional.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_lat      <= '0;
      blk_base     <= '0;
      srch_base    <= '0;
      blk_rd_addr  <= '0;
      srch_rd_addr <= '0;
      word_cnt     <= '0;
      row_cnt      <= '0;
    end else if (start) begin
      idx_lat      <= blk_index;
      blk_base     <= blk_addr;
      blk_rd_addr  <= blk_addr;
      srch_base    <= srch_addr + srch_vofs;
      srch_rd_addr <= srch_addr + srch_vofs;
      word_cnt     <= '0;
      row_cnt      <= '0;
    end else if (state == st_read && !read_last) begin
      if (word_cnt == last_word) begin
        word_cnt     <= '0;
        row_cnt      <= row_cnt + 1'b1;
        blk_base     <= blk_base + blk_step;
        blk_rd_addr  <= blk_base + blk_step;
        srch_base    <= srch_base + srch_step;
        srch_rd_addr <= srch_base + srch_step;
      end else begin
        word_cnt     <= word_cnt + 1'b1;
        srch_rd_addr <= srch_rd_addr + 16'd1;
        if (int'(word_cnt) + 1 < bw) blk_rd_addr <= blk_rd_addr + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state != st_drain) drain_cnt <= '0;
    else                            drain_cnt <= drain_cnt + 1'b1;
  end

  // Tags travel alongside the memory latency so data is matched to its word slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < rd_lat; i++) pipe_w[i] <= '0;
    end else begin
      pipe_v[0] <= (state == st_read);
      pipe_w[0] <= word_cnt;
      for (int i = 1; i < rd_lat; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_w[i] <= pipe_w[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_row  <= '0;
      srch_row <= '0;
    end else if (pipe_v[rd_lat-1]) begin
      srch_row[int'(pipe_w[rd_lat-1])*word_bits +: word_bits] <= srch_rd_data;
      if (int'(pipe_w[rd_lat-1]) < bw)
        blk_row[int'(pipe_w[rd_lat-1])*word_bits +: word_bits] <= blk_rd_data;
    end
  end

  // The last search word of a row is still on the bus, so splice it in directly.
  always_comb begin
    srch_full = srch_row;
    srch_full[(sw-1)*word_bits +: word_bits] = srch_rd_data;
    for (int d = 0; d < nc; d++) begin
      sad_row[d] = '0;
      for (int x = 0; x < block_width; x++)
        sad_row[d] = sad_row[d] + 16'(abs_diff(blk_row[x*8 +: 8], srch_full[(x+d)*8 +: 8]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      for (int d = 0; d < nc; d++) acc[d] <= '0;
    end else if (row_last) begin
      for (int d = 0; d < nc; d++) acc[d] <= acc[d] + sad_row[d];
    end
  end

  always_comb begin
    cand_sad       = acc[scan_idx];
    take_cand      = (scan_idx == '0) || (cand_sad < best_sad);
    scan_best_sad  = take_cand ? cand_sad : best_sad;
    scan_best_disp = take_cand ? scan_idx : best_disp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx     <= '0;
      best_sad     <= '0;
      best_disp    <= '0;
      result_index <= '0;
      result_disp  <= '0;
      result_sad   <= '0;
    end else if (state == st_scan) begin
      scan_idx  <= scan_idx + 1'b1;
      best_sad  <= scan_best_sad;
      best_disp <= scan_best_disp;
      if (scan_idx == last_cand) begin
        result_index <= idx_lat;
        result_disp  <= 8'(scan_best_disp);
        result_sad   <= scan_best_sad;
      end
    end else begin
      scan_idx <= '0;
    end
  end

endmodule
